// File: rtl/timer_irq_unit_pkg.sv
// rtl/timer_irq_unit_pkg.sv - register map and TCON bit layout shared by the timer block
package timer_irq_unit_pkg;

  localparam logic [4:0] TH_OFS      = 5'h00;
  localparam logic [4:0] TL_OFS      = 5'h04;
  localparam logic [4:0] TCON_OFS    = 5'h08;
  localparam logic [4:0] SYSTICK_OFS = 5'h14;

  localparam int EN_BIT = 0;
  localparam int IE_BIT = 1;
  localparam int ST_BIT = 2;

  typedef enum logic [2:0] {
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_SYSTICK,
    REG_NONE
  } reg_sel_e;

  // Byte offset inside the window to register select; low two bits are don't-care.
  function automatic reg_sel_e decode_ofs(input logic [2:0] word);
    logic [4:0] ofs;
    ofs = {word, 2'b00};
    case (ofs)
      TH_OFS:      decode_ofs = REG_TH;
      TL_OFS:      decode_ofs = REG_TL;
      TCON_OFS:    decode_ofs = REG_TCON;
      SYSTICK_OFS: decode_ofs = REG_SYSTICK;
      default:     decode_ofs = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/timer_irq_unit_if.sv
// rtl/timer_irq_unit_if.sv - single-cycle peripheral load/store bus plus interrupt line
interface timer_irq_unit_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;

  modport master (output rd, wr, addr, wdata, input rdata, irqout);
  modport slave  (input rd, wr, addr, wdata, output rdata, irqout);
endinterface

// File: rtl/timer_irq_unit_prescaler.sv
// rtl/timer_irq_unit_prescaler.sv - divides clk by PRESCALE into a one-cycle tick while enabled
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE) + 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Disabled or wrapping both land on zero, so re-enabling always starts a full period.
  always_comb begin
    cnt_d = '0;
    if (en && !tick) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_irq_unit.sv
// rtl/timer_irq_unit.sv - memory-mapped reload timer with sticky interrupt and free-running systick
module timer_irq_unit
  import timer_irq_unit_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int          PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  timer_irq_unit_if.slave  bus
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [31:0] systick_q;

  logic        tick;
  logic        hit;
  reg_sel_e    sel;
  logic        wr_th, wr_tl, wr_tcon;
  logic        overflow;
  logic        unused_addr;

  assign unused_addr = &{1'b0, bus.addr[1:0]};

  assign hit = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign sel = hit ? decode_ofs(bus.addr[4:2]) : REG_NONE;

  assign wr_th   = bus.wr && (sel == REG_TH);
  assign wr_tl   = bus.wr && (sel == REG_TL);
  assign wr_tcon = bus.wr && (sel == REG_TCON);

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (tcon_q[EN_BIT]),
    .tick  (tick)
  );

  // A software TL write suppresses the whole overflow event, including the ST set.
  assign overflow = tick && (tl_q == 32'hFFFFFFFF) && !wr_tl;

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.rd) begin
      case (sel)
        REG_TH:      bus.rdata = th_q;
        REG_TL:      bus.rdata = tl_q;
        REG_TCON:    bus.rdata = {29'h0, tcon_q};
        REG_SYSTICK: bus.rdata = systick_q;
        default:     bus.rdata = 32'h0;
      endcase
    end
  end

  assign bus.irqout = tcon_q[IE_BIT] & tcon_q[ST_BIT];

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (wr_th) th_d = bus.wdata;

    // Reload reads th_q, so a TH write in the same cycle only affects the next wrap.
    if (wr_tl)         tl_d = bus.wdata;
    else if (overflow) tl_d = th_q;
    else if (tick)     tl_d = tl_q + 32'd1;

    if (wr_tcon)
      tcon_d = bus.wdata[2:0];
    else if (overflow && tcon_q[IE_BIT])
      tcon_d[ST_BIT] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= 32'h0;
      tl_q      <= 32'h0;
      tcon_q    <= 3'h0;
      systick_q <= 32'h0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_timer_irq_unit.sv
// tb/tb_timer_irq_unit.sv - directed bench for timer_irq_unit at PRESCALE 1 and 4
module tb_timer_irq_unit;

  localparam logic [31:0] A_TH   = 32'h40000000;
  localparam logic [31:0] A_TL   = 32'h40000004;
  localparam logic [31:0] A_TCON = 32'h40000008;
  localparam logic [31:0] A_SYS  = 32'h40000014;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  timer_irq_unit_if b1 ();
  timer_irq_unit_if b4 ();

  timer_irq_unit #(.BASE_ADDR(32'h40000000), .PRESCALE(1)) dut1 (
    .clk (clk), .reset (reset), .bus (b1)
  );
  timer_irq_unit #(.BASE_ADDR(32'h40000000), .PRESCALE(4)) dut4 (
    .clk (clk), .reset (reset), .bus (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; the write commits on the following rising edge.
  task automatic wr_reg(input bit s, input logic [31:0] a, input logic [31:0] d);
    if (s) begin b4.wr = 1'b1; b4.addr = a; b4.wdata = d; end
    else   begin b1.wr = 1'b1; b1.addr = a; b1.wdata = d; end
    @(negedge clk);
    b1.wr = 1'b0;
    b4.wr = 1'b0;
  endtask

  task automatic rd_reg(input bit s, input logic [31:0] a, output logic [31:0] d);
    if (s) begin b4.rd = 1'b1; b4.addr = a; end
    else   begin b1.rd = 1'b1; b1.addr = a; end
    #1;
    d = s ? b4.rdata : b1.rdata;
    b1.rd = 1'b0;
    b4.rd = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    wr_reg(0, A_TL, 32'd5);
    wr_reg(0, A_TCON, 32'd7);
    checks++;
    if (b1.irqout !== 1'b1) begin
      $display("FAIL reset_pre_irq: got %b expected 1", b1.irqout); errors++;
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (b1.irqout !== 1'b0) begin
      $display("FAIL reset_async_irq: got %b expected 0", b1.irqout); errors++;
    end
    @(negedge clk);
    rd_reg(0, A_TH, d);
    checks++; if (d !== 32'h0) begin $display("FAIL reset_th: got %h expected 0", d); errors++; end
    rd_reg(0, A_TL, d);
    checks++; if (d !== 32'h0) begin $display("FAIL reset_tl: got %h expected 0", d); errors++; end
    rd_reg(0, A_TCON, d);
    checks++; if (d !== 32'h0) begin $display("FAIL reset_tcon: got %h expected 0", d); errors++; end
    rd_reg(0, A_SYS, d);
    checks++; if (d !== 32'h0) begin $display("FAIL reset_systick: got %h expected 0", d); errors++; end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    wr_reg(0, A_TH, 32'hFFFFFFF0);
    wr_reg(0, A_TL, 32'hFFFFFFFE);
    wr_reg(0, A_TCON, 32'd3);
    rd_reg(0, A_TL, d);
    checks++; if (d !== 32'hFFFFFFFE) begin $display("FAIL ovf_tl0: got %h expected fffffffe", d); errors++; end
    step(1);
    rd_reg(0, A_TL, d);
    checks++; if (d !== 32'hFFFFFFFF) begin $display("FAIL ovf_tl1: got %h expected ffffffff", d); errors++; end
    checks++; if (b1.irqout !== 1'b0) begin $display("FAIL ovf_irq1: got %b expected 0", b1.irqout); errors++; end
    step(1);
    rd_reg(0, A_TL, d);
    checks++; if (d !== 32'hFFFFFFF0) begin $display("FAIL ovf_reload: got %h expected fffffff0", d); errors++; end
    checks++; if (b1.irqout !== 1'b1) begin $display("FAIL ovf_irq2: got %b expected 1", b1.irqout); errors++; end
    rd_reg(0, A_TCON, d);
    checks++; if (d !== 32'h7) begin $display("FAIL ovf_tcon: got %h expected 7", d); errors++; end
  endtask

  task automatic test_clear();
    logic [31:0] d;
    wr_reg(0, A_TCON, 32'd3);
    checks++; if (b1.irqout !== 1'b0) begin $display("FAIL clr_irq: got %b expected 0", b1.irqout); errors++; end
    rd_reg(0, A_TCON, d);
    checks++; if (d !== 32'h3) begin $display("FAIL clr_tcon: got %h expected 3", d); errors++; end
    wr_reg(0, A_TL, 32'hFFFFFFFE);
    step(1);
    wr_reg(0, A_TCON, 32'd1);
    checks++; if (b1.irqout !== 1'b0) begin $display("FAIL clr_ie0_irq: got %b expected 0", b1.irqout); errors++; end
    rd_reg(0, A_TCON, d);
    checks++; if (d !== 32'h1) begin $display("FAIL clr_ie0_tcon: got %h expected 1", d); errors++; end
    rd_reg(0, A_TL, d);
    checks++; if (d !== 32'hFFFFFFF0) begin $display("FAIL clr_ie0_tl: got %h expected fffffff0", d); errors++; end
  endtask

  task automatic test_write_priority();
    logic [31:0] d;
    wr_reg(0, A_TCON, 32'd3);
    wr_reg(0, A_TL, 32'hFFFFFFFF);
    wr_reg(0, A_TL, 32'h00001234);
    rd_reg(0, A_TL, d);
    checks++; if (d !== 32'h1234) begin $display("FAIL pri_tl: got %h expected 1234", d); errors++; end
    rd_reg(0, A_TCON, d);
    checks++; if (d !== 32'h3) begin $display("FAIL pri_tl_st: got %h expected 3", d); errors++; end
    checks++; if (b1.irqout !== 1'b0) begin $display("FAIL pri_tl_irq: got %b expected 0", b1.irqout); errors++; end
    wr_reg(0, A_TL, 32'hFFFFFFFF);
    wr_reg(0, A_TH, 32'd7);
    rd_reg(0, A_TL, d);
    checks++; if (d !== 32'hFFFFFFF0) begin $display("FAIL pri_th_old: got %h expected fffffff0", d); errors++; end
    rd_reg(0, A_TH, d);
    checks++; if (d !== 32'h7) begin $display("FAIL pri_th_new: got %h expected 7", d); errors++; end
    checks++; if (b1.irqout !== 1'b1) begin $display("FAIL pri_th_irq: got %b expected 1", b1.irqout); errors++; end
    wr_reg(0, A_TCON, 32'd3);
    wr_reg(0, A_TL, 32'hFFFFFFFF);
    step(1);
    rd_reg(0, A_TL, d);
    checks++; if (d !== 32'h7) begin $display("FAIL pri_th_next: got %h expected 7", d); errors++; end
    wr_reg(0, A_TCON, 32'd0);
    step(2);
    rd_reg(0, A_TL, d);
    checks++; if (d !== 32'h8) begin $display("FAIL pri_en_clear: got %h expected 8", d); errors++; end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    logic [31:0] s0;
    wr_reg(1, A_TCON, 32'd1);
    rd_reg(1, A_SYS, s0);
    step(11);
    rd_reg(1, A_TL, d);
    checks++; if (d !== 32'h2) begin $display("FAIL ps_tl11: got %h expected 2", d); errors++; end
    step(1);
    rd_reg(1, A_TL, d);
    checks++; if (d !== 32'h3) begin $display("FAIL ps_tl12: got %h expected 3", d); errors++; end
    rd_reg(1, A_SYS, d);
    checks++; if (d !== s0 + 32'd12) begin $display("FAIL ps_sys12: got %h expected %h", d, s0 + 32'd12); errors++; end
    wr_reg(1, A_TCON, 32'd0);
    step(5);
    rd_reg(1, A_TL, d);
    checks++; if (d !== 32'h3) begin $display("FAIL ps_tl_hold: got %h expected 3", d); errors++; end
    rd_reg(1, A_SYS, d);
    checks++; if (d !== s0 + 32'd18) begin $display("FAIL ps_sys_en0: got %h expected %h", d, s0 + 32'd18); errors++; end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic [31:0] s0;
    rd_reg(0, 32'h4000000C, d);
    checks++; if (d !== 32'h0) begin $display("FAIL dec_0c: got %h expected 0", d); errors++; end
    rd_reg(0, 32'h40000018, d);
    checks++; if (d !== 32'h0) begin $display("FAIL dec_18: got %h expected 0", d); errors++; end
    rd_reg(0, 32'h40000003, d);
    checks++; if (d !== 32'h7) begin $display("FAIL dec_lowbits: got %h expected 7", d); errors++; end
    rd_reg(0, A_SYS, s0);
    wr_reg(0, A_SYS, 32'd5);
    rd_reg(0, A_SYS, d);
    checks++; if (d !== s0 + 32'd1) begin $display("FAIL dec_sys_ro: got %h expected %h", d, s0 + 32'd1); errors++; end
    wr_reg(0, 32'h40000010, 32'hDEADBEEF);
    rd_reg(0, 32'h40000010, d);
    checks++; if (d !== 32'h0) begin $display("FAIL dec_10: got %h expected 0", d); errors++; end
    b1.addr = A_TH;
    b1.rd   = 1'b0;
    #1;
    checks++; if (b1.rdata !== 32'h0) begin $display("FAIL dec_rd0: got %h expected 0", b1.rdata); errors++; end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    b1.rd = 1'b0; b1.wr = 1'b0; b1.addr = 32'h0; b1.wdata = 32'h0;
    b4.rd = 1'b0; b4.wr = 1'b0; b4.addr = 32'h0; b4.wdata = 32'h0;
    step(2);
    reset = 1'b0;
    step(1);
    test_reset();
    test_overflow();
    test_clear();
    test_write_priority();
    test_prescale();
    step(1);
    test_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
